// File: rtl/mux_arb_pkg.sv
// Shared types and helpers for the mux_arb arbitrated N:1 multiplexor.
package mux_arb_pkg;

  typedef enum logic [1:0] {
    ARB_FIXED  = 2'd0,
    ARB_RR     = 2'd1,
    ARB_FORCED = 2'd2
  } arb_mode_e;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Next round-robin start after a grant to idx; never yields a value >= ports.
  function automatic int unsigned ptr_wrap(input int unsigned idx, input int unsigned ports);
    return (idx + 32'd1 >= ports) ? 32'd0 : idx + 32'd1;
  endfunction

endpackage

// File: rtl/mux_arb_rr_pick.sv
// Combinational rotating-priority picker: first request at or above ptr_i, wrapping.
module arb_rr_pick
  import mux_arb_pkg::*;
#(
  parameter int PORTS = 4,
  parameter int IW    = idx_width(PORTS)
) (
  input  logic [PORTS-1:0] req_i,
  input  logic [IW-1:0]    ptr_i,
  output logic [PORTS-1:0] gnt_o,
  output logic [IW-1:0]    idx_o,
  output logic             any_o
);

  localparam logic [IW:0] LIM = (IW+1)'(PORTS);

  // Scan PORTS candidates starting at ptr_i; the first live request wins.
  always_comb begin : pick
    logic [IW:0] j;
    gnt_o = {PORTS{1'b0}};
    idx_o = {IW{1'b0}};
    any_o = 1'b0;
    j     = {(IW+1){1'b0}};
    for (int k = 0; k < PORTS; k++) begin
      j = {1'b0, ptr_i} + (IW+1)'(k);
      if (j >= LIM) begin
        j = j - LIM;
      end else begin
        j = j;
      end
      if (!any_o && req_i[j[IW-1:0]]) begin
        any_o               = 1'b1;
        gnt_o[j[IW-1:0]]    = 1'b1;
        idx_o               = j[IW-1:0];
      end else begin
        any_o = any_o;
      end
    end
  end

endmodule

// File: rtl/mux_arb.sv
// N:1 valid/ready multiplexor with fixed, round-robin or forced arbitration
// feeding a single registered output stage.
module mux_arb
  import mux_arb_pkg::*;
#(
  parameter int SIZE  = 64,
  parameter int PORTS = 4,
  parameter int MODE  = 1
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic [SIZE-1:0]                in [PORTS],
  input  logic [PORTS-1:0]               in_valid,
  output logic [PORTS-1:0]               in_ready,
  input  logic [idx_width(PORTS)-1:0]    sel,
  output logic [SIZE-1:0]                out,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [idx_width(PORTS)-1:0]    out_port
);

  localparam int          IW      = idx_width(PORTS);
  localparam arb_mode_e   MODE_E  = arb_mode_e'(MODE);
  localparam logic [IW:0] IDX_LIM = (IW+1)'(PORTS);

  logic [SIZE-1:0]  out_q, out_d;
  logic             valid_q, valid_d;
  logic [IW-1:0]    port_q, port_d;
  logic [IW-1:0]    ptr_q, ptr_d;

  logic [PORTS-1:0] pick_gnt_s, grant_s;
  logic [IW-1:0]    pick_idx_s, grant_idx_s, start_s;
  logic             pick_any_s, free_s, xfer_s;
  logic [SIZE-1:0]  sel_data_s;

  assign start_s = (MODE_E == ARB_RR) ? ptr_q : {IW{1'b0}};

  arb_rr_pick #(.PORTS(PORTS), .IW(IW)) u_pick (
    .req_i (in_valid),
    .ptr_i (start_s),
    .gnt_o (pick_gnt_s),
    .idx_o (pick_idx_s),
    .any_o (pick_any_s)
  );

  // Grant selection; forced mode ignores every channel except sel.
  always_comb begin
    grant_s     = {PORTS{1'b0}};
    grant_idx_s = {IW{1'b0}};
    case (MODE_E)
      ARB_FIXED, ARB_RR: begin
        grant_s     = pick_gnt_s;
        grant_idx_s = pick_idx_s;
      end
      ARB_FORCED: begin
        if ({1'b0, sel} < IDX_LIM) begin
          grant_s[sel] = in_valid[sel];
          grant_idx_s  = sel;
        end else begin
          grant_s = {PORTS{1'b0}};
        end
      end
      default: grant_s = {PORTS{1'b0}};
    endcase
  end

  assign free_s   = !valid_q || out_ready;
  assign in_ready = reset_n ? (grant_s & {PORTS{free_s}}) : {PORTS{1'b0}};
  assign xfer_s   = |in_ready;

  // One-hot AND-OR data select.
  always_comb begin
    sel_data_s = {SIZE{1'b0}};
    for (int i = 0; i < PORTS; i++) begin
      sel_data_s = sel_data_s | (in[i] & {SIZE{grant_s[i]}});
    end
  end

  // Output stage and round-robin pointer next state.
  always_comb begin
    out_d   = out_q;
    port_d  = port_q;
    valid_d = valid_q;
    ptr_d   = ptr_q;
    if (xfer_s) begin
      out_d   = sel_data_s;
      port_d  = grant_idx_s;
      valid_d = 1'b1;
      if (MODE_E == ARB_RR) begin
        ptr_d = IW'(ptr_wrap(32'(grant_idx_s), PORTS));
      end else begin
        ptr_d = ptr_q;
      end
    end else begin
      valid_d = valid_q && !out_ready;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_q   <= {SIZE{1'b0}};
      valid_q <= 1'b0;
      port_q  <= {IW{1'b0}};
      ptr_q   <= {IW{1'b0}};
    end else begin
      out_q   <= out_d;
      valid_q <= valid_d;
      port_q  <= port_d;
      ptr_q   <= ptr_d;
    end
  end

  assign out       = out_q;
  assign out_valid = valid_q;
  assign out_port  = port_q;

endmodule
